lp_fltr_mc: RTL

//  Multi-channel, time-multiplexed binomial low-pass FIR for signed samples. Per-channel

---
 rtl/lp_fltr_pkg.sv | 34 +++
 rtl/lp_fltr_mc_if.sv | 31 +++
 rtl/lp_fltr_hist.sv | 55 +++++
 rtl/lp_fltr_mc.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/lp_fltr_pkg.sv
// Shared types and constants for the multi-channel binomial low-pass filter.
package lp_fltr_pkg;

    // Kernel selection travels with every accepted sample.
    typedef enum logic {
        LP_MODE_3TAP = 1'b0,   // [1 2 1] / 4
        LP_MODE_5TAP = 1'b1    // [1 4 6 4 1] / 16
    } lp_mode_e;

    // Taps per kernel evaluation (current sample + four past samples).
    localparam int LP_TAPS       = 5;
    // History kept per channel; always deep enough for the 5-tap kernel.
    localparam int LP_HIST_DEPTH = 4;

    // Kernel weights (outer taps are always 1).
    localparam int LP_W3_CTR  = 2;
    localparam int LP_W5_NEAR = 4;
    localparam int LP_W5_CTR  = 6;

    // Normalising shifts: weight sum is 4 and 16 respectively.
    localparam int LP_SHIFT_3TAP = 2;
    localparam int LP_SHIFT_5TAP = 4;

    // Width of the weighted sum before normalisation.
    function automatic int sumw(input int dw, input lp_mode_e mode);
        return (mode == LP_MODE_5TAP) ? dw + LP_SHIFT_5TAP : dw + LP_SHIFT_3TAP;
    endfunction

    // Channel index width, never below one bit.
    function automatic int lp_chw(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/lp_fltr_mc_if.sv
// Sample stream bus between the front end and the low-pass filter.
//
// Handshake: din_vld qualifies din/din_ch/mode in the cycle it is high; there is
// no ready, the filter takes one sample per clock-enabled cycle. dout_vld is a
// one-cycle pulse qualifying dout/dout_ch; the consumer cannot stall it.
interface lp_fltr_mc_if
    import lp_fltr_pkg::*;
#(
    parameter int DW  = 8,
    parameter int CHW = 2
);
    logic signed [DW-1:0]  din;
    logic        [CHW-1:0] din_ch;
    logic                  din_vld;
    lp_mode_e              mode;
    logic signed [DW-1:0]  dout;
    logic        [CHW-1:0] dout_ch;
    logic                  dout_vld;

    // Sample source side.
    modport master (
        output din, din_ch, din_vld, mode,
        input  dout, dout_ch, dout_vld
    );

    // Filter side.
    modport slave (
        input  din, din_ch, din_vld, mode,
        output dout, dout_ch, dout_vld
    );
endinterface

// File: rtl/lp_fltr_hist.sv
// Per-channel four-deep sample history with global flush.
// rd_o[0] is x1 (most recent) up to rd_o[3] = x4 for the addressed channel.
module lp_fltr_hist
    import lp_fltr_pkg::*;
#(
    parameter int DW  = 8,
    parameter int CH  = 4,
    parameter int CHW = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_i,  // already qualified by ce
    input  logic                                wr_i,     // accepted sample, already qualified by ce
    input  logic [CHW-1:0]                      ch_i,
    input  logic [DW-1:0]                       x0_i,
    output logic [LP_HIST_DEPTH-1:0][DW-1:0]    rd_o
);

    logic [LP_HIST_DEPTH-1:0][DW-1:0] hist_q [CH];
    logic [LP_HIST_DEPTH-1:0][DW-1:0] hist_d [CH];

    // Read for the sample being accepted; a flush in the same cycle means it sees zeros.
    // Writes land on the accepting edge, so a same-channel sample next cycle reads fresh taps.
    always_comb begin
        rd_o = hist_q[ch_i];
        if (flush_i) begin
            rd_o = '0;
        end
    end

    // Next history: clear everything on flush, then shift the new sample into its channel.
    always_comb begin
        hist_d = hist_q;
        if (flush_i) begin
            for (int c = 0; c < CH; c++) begin
                hist_d[c] = '0;
            end
        end
        if (wr_i) begin
            hist_d[ch_i] = {hist_d[ch_i][LP_HIST_DEPTH-2:0], x0_i};
        end
    end

    // History storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                hist_q[c] <= '0;
            end
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/lp_fltr_mc.sv
// Multi-channel time-multiplexed binomial low-pass FIR.
// Three enabled cycles from accept to dout_vld: capture, partial sums, final sum/shift.
module lp_fltr_mc
    import lp_fltr_pkg::*;
#(
    parameter int  DW    = 8,
    parameter int  CH    = 4,
    parameter int  ROUND = 0,
    localparam int CHW   = lp_chw(CH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         flush,
    lp_fltr_mc_if.slave  bus
);

    localparam int SW = sumw(DW, LP_MODE_5TAP);
    localparam logic [CHW:0]          CH_LIM    = (CHW+1)'(CH);
    localparam logic signed [SW-1:0]  W3_CTR    = SW'(LP_W3_CTR);
    localparam logic signed [SW-1:0]  W5_NEAR   = SW'(LP_W5_NEAR);
    localparam logic signed [SW-1:0]  W5_CTR    = SW'(LP_W5_CTR);
    localparam logic signed [SW-1:0]  RND_3TAP  = SW'(1 << (LP_SHIFT_3TAP - 1));
    localparam logic signed [SW-1:0]  RND_5TAP  = SW'(1 << (LP_SHIFT_5TAP - 1));

    logic                              accept;
    logic                              flush_en;
    logic [LP_HIST_DEPTH-1:0][DW-1:0]  hist_rd;

    logic                              s1_vld_q;
    logic [CHW-1:0]                    s1_ch_q;
    lp_mode_e                          s1_mode_q;
    logic [LP_TAPS-1:0][DW-1:0]        s1_x_q;

    logic signed [SW-1:0]              xe [LP_TAPS];
    logic signed [SW-1:0]              s2_a_d, s2_b_d;
    logic                              s2_vld_q;
    logic [CHW-1:0]                    s2_ch_q;
    lp_mode_e                          s2_mode_q;
    logic signed [SW-1:0]              s2_a_q, s2_b_q;

    logic signed [SW-1:0]              sum_d;
    logic signed [DW-1:0]              dout_d;
    logic signed [DW-1:0]              dout_q;
    logic [CHW-1:0]                    dout_ch_q;
    logic                              dout_vld_q;

    // Out-of-range channels are dropped entirely; the extra index bit avoids a constant compare.
    assign accept   = ce & bus.din_vld & ({1'b0, bus.din_ch} < CH_LIM);
    assign flush_en = ce & flush;

    lp_fltr_hist #(
        .DW  (DW),
        .CH  (CH),
        .CHW (CHW)
    ) u_hist (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_en),
        .wr_i    (accept),
        .ch_i    (bus.din_ch),
        .x0_i    (bus.din),
        .rd_o    (hist_rd)
    );

    // Stage 1: capture the sample, its channel taps and its kernel choice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_ch_q   <= '0;
            s1_mode_q <= LP_MODE_3TAP;
            s1_x_q    <= '0;
        end else if (ce) begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_ch_q   <= bus.din_ch;
                s1_mode_q <= bus.mode;
                s1_x_q    <= {hist_rd, bus.din};
            end
        end
    end

    // Stage 2 logic: outer taps in one partial sum, weighted inner taps in the other.
    always_comb begin
        for (int k = 0; k < LP_TAPS; k++) begin
            xe[k] = SW'($signed(s1_x_q[k]));
        end
        s2_a_d = '0;
        s2_b_d = '0;
        if (s1_mode_q == LP_MODE_5TAP) begin
            s2_a_d = xe[0] + xe[4];
            s2_b_d = (xe[1] + xe[3]) * W5_NEAR + xe[2] * W5_CTR;
        end else begin
            s2_a_d = xe[0] + xe[2];
            s2_b_d = xe[1] * W3_CTR;
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_ch_q   <= '0;
            s2_mode_q <= LP_MODE_3TAP;
            s2_a_q    <= '0;
            s2_b_q    <= '0;
        end else if (ce) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_ch_q   <= s1_ch_q;
                s2_mode_q <= s1_mode_q;
                s2_a_q    <= s2_a_d;
                s2_b_q    <= s2_b_d;
            end
        end
    end

    // Stage 3 logic: final sum, optional half-LSB, arithmetic shift. Unity DC gain keeps it in DW.
    always_comb begin
        sum_d  = s2_a_q + s2_b_q;
        dout_d = '0;
        if (s2_mode_q == LP_MODE_5TAP) begin
            if (ROUND != 0) begin
                sum_d = sum_d + RND_5TAP;
            end
            dout_d = DW'(sum_d >>> LP_SHIFT_5TAP);
        end else begin
            if (ROUND != 0) begin
                sum_d = sum_d + RND_3TAP;
            end
            dout_d = DW'(sum_d >>> LP_SHIFT_3TAP);
        end
    end

    // Output register: data holds between results, valid pulses only on enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q     <= '0;
            dout_ch_q  <= '0;
            dout_vld_q <= 1'b0;
        end else if (ce) begin
            dout_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                dout_q    <= dout_d;
                dout_ch_q <= s2_ch_q;
            end
        end else begin
            dout_vld_q <= 1'b0;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_ch  = dout_ch_q;
    assign bus.dout_vld = dout_vld_q;

endmodule
